// File: rtl/gate_chk_pkg.sv
// Shared definitions for the gate response checker: gate_y bit positions,
// FSM state encoding and the golden truth function for a 2-input gate block.
package gate_chk_pkg;

  localparam int AND_I  = 0;
  localparam int NAND_I = 1;
  localparam int OR_I   = 2;
  localparam int NOR_I  = 3;
  localparam int XOR_I  = 4;
  localparam int XNOR_I = 5;
  localparam int NOT_I  = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } chk_state_t;

  function automatic logic [6:0] golden(input logic a, input logic b);
    logic [6:0] y;
    y         = '0;
    y[AND_I]  = a & b;
    y[NAND_I] = ~(a & b);
    y[OR_I]   = a | b;
    y[NOR_I]  = ~(a | b);
    y[XOR_I]  = a ^ b;
    y[XNOR_I] = ~(a ^ b);
    y[NOT_I]  = ~a;
    return y;
  endfunction

endpackage

// File: rtl/gate_chk_golden.sv
// Purely combinational golden response of a 2-input gate block; kept separate
// so other gate-level checkers can reuse it.
module gate_golden_model
  import gate_chk_pkg::*;
(
  input  logic       a,
  input  logic       b,
  output logic [6:0] y
);

  assign y = golden(a, b);

endmodule

// File: rtl/gate_response_checker.sv
// BIST-style response analyser: sweeps {A,B} through 00..11, samples the gate
// block's seven outputs after a settle delay and accumulates mismatch info.
module gate_response_checker
  import gate_chk_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int LOOPS         = 1,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [6:0]       gate_y,
  output logic             drv_a,
  output logic             drv_b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [6:0]       err_mask,
  output logic [1:0]       first_fail
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [7:0] LAST_LOOP   = 8'(LOOPS - 1);

  chk_state_t state, state_nxt;
  logic [1:0] vec;
  logic [7:0] loop_cnt;
  logic [3:0] settle_cnt;
  logic       armed;
  logic [6:0] golden_vec;
  logic [6:0] diff;
  logic       mismatch;
  logic       accept;
  logic       last_vec;

  gate_golden_model u_golden (
    .a (vec[1]),
    .b (vec[0]),
    .y (golden_vec)
  );

  assign drv_a    = vec[1];
  assign drv_b    = vec[0];
  assign diff     = gate_y ^ golden_vec;
  assign mismatch = |diff;
  assign accept   = (state == IDLE) && start && armed;
  assign last_vec = (vec == 2'd3) && (loop_cnt == LAST_LOOP);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SETTLE;
      SETTLE:  if (settle_cnt == 4'd0) state_nxt = CHECK;
      CHECK:   state_nxt = last_vec ? DONE : SETTLE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // armed stays low for the first edge after reset release so a start
  // coinciding with deassertion is not taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) armed <= 1'b0;
    else        armed <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec        <= 2'd0;
      loop_cnt   <= 8'd0;
      settle_cnt <= 4'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      err_mask   <= '0;
      first_fail <= 2'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            vec        <= 2'd0;
            loop_cnt   <= 8'd0;
            settle_cnt <= SETTLE_LOAD;
            busy       <= 1'b1;
            pass       <= 1'b0;
            err_count  <= '0;
            err_mask   <= '0;
            first_fail <= 2'd0;
          end
        end
        SETTLE: begin
          if (settle_cnt != 4'd0) settle_cnt <= settle_cnt - 4'd1;
        end
        CHECK: begin
          if (mismatch) begin
            if (err_count != '1) err_count <= err_count + 1'b1;
            if (err_count == '0) first_fail <= vec;
            err_mask <= err_mask | diff;
          end
          if (!last_vec) begin
            vec        <= vec + 2'd1;
            settle_cnt <= SETTLE_LOAD;
            if (vec == 2'd3) loop_cnt <= loop_cnt + 8'd1;
          end
        end
        DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
          pass <= (err_count == '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_response_checker.sv
// Bench for gate_response_checker: three parameterisations driven by a
// behavioural gate block with injectable stuck-at-0 and inversion faults.
module tb_gate_response_checker;

  typedef struct {
    logic       pass;
    logic [7:0] cnt;
    logic [6:0] mask;
    logic [1:0] ff;
  } exp_t;

  typedef struct {
    logic [6:0] stuck0;
    logic [6:0] inv;
    exp_t       e;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [2:0] start_v;
  logic [6:0] stuck [3];
  logic [6:0] inv [3];

  logic da0, db0, bsy0, dn0, ps0;
  logic da1, db1, bsy1, dn1, ps1;
  logic da2, db2, bsy2, dn2, ps2;
  logic [7:0] ec0, ec1;
  logic [1:0] ec2;
  logic [6:0] em0, em1, em2, gy0, gy1, gy2;
  logic [1:0] ff0, ff1, ff2;

  int   sel;
  logic s_da, s_db, s_busy, s_done, s_pass;
  logic [7:0] s_ec;
  logic [6:0] s_em;
  logic [1:0] s_ff;

  int n_vec = 0;
  int n_bad = 0;
  exp_t sb[$];
  vec_t tbl[7];

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_gates(input logic a, input logic b);
    logic [6:0] y;
    y[0] = a & b;
    y[1] = !(a & b);
    y[2] = a | b;
    y[3] = !(a | b);
    y[4] = a ^ b;
    y[5] = !(a ^ b);
    y[6] = !a;
    return y;
  endfunction

  assign gy0 = (ref_gates(da0, db0) & ~stuck[0]) ^ inv[0];
  assign gy1 = (ref_gates(da1, db1) & ~stuck[1]) ^ inv[1];
  assign gy2 = (ref_gates(da2, db2) & ~stuck[2]) ^ inv[2];

  gate_response_checker dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .gate_y(gy0),
    .drv_a(da0), .drv_b(db0), .busy(bsy0), .done(dn0), .pass(ps0),
    .err_count(ec0), .err_mask(em0), .first_fail(ff0)
  );

  gate_response_checker #(.SETTLE_CYCLES(2), .LOOPS(3), .ERR_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .gate_y(gy1),
    .drv_a(da1), .drv_b(db1), .busy(bsy1), .done(dn1), .pass(ps1),
    .err_count(ec1), .err_mask(em1), .first_fail(ff1)
  );

  gate_response_checker #(.SETTLE_CYCLES(2), .LOOPS(2), .ERR_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .gate_y(gy2),
    .drv_a(da2), .drv_b(db2), .busy(bsy2), .done(dn2), .pass(ps2),
    .err_count(ec2), .err_mask(em2), .first_fail(ff2)
  );

  always_comb begin
    s_da = da0; s_db = db0; s_busy = bsy0; s_done = dn0; s_pass = ps0;
    s_ec = ec0; s_em = em0; s_ff = ff0;
    case (sel)
      1: begin
        s_da = da1; s_db = db1; s_busy = bsy1; s_done = dn1; s_pass = ps1;
        s_ec = ec1; s_em = em1; s_ff = ff1;
      end
      2: begin
        s_da = da2; s_db = db2; s_busy = bsy2; s_done = dn2; s_pass = ps2;
        s_ec = {6'd0, ec2}; s_em = em2; s_ff = ff2;
      end
      default: ;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Caller is positioned at a falling edge; returns one cycle after done.
  task automatic run_one(input int d, input logic [6:0] st, input logic [6:0] iv,
                         input exp_t e, input int lat, input bit chk_drv,
                         input bit repulse);
    int   c;
    bit   drv_ok;
    exp_t x;
    sel      = d;
    stuck[d] = st;
    inv[d]   = iv;
    sb.push_back(e);
    start_v[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[d] = 1'b0;
    chk("start_ack", {30'd0, s_busy, s_pass}, 32'h2);
    drv_ok = 1'b1;
    c = 0;
    while (!s_done && c < 400) begin
      if (chk_drv && c < 12 && {s_da, s_db} !== 2'(c / 3)) drv_ok = 1'b0;
      if (repulse && c == 4) start_v[d] = 1'b1;
      if (repulse && c == 5) start_v[d] = 1'b0;
      @(negedge clk);
      c++;
    end
    x = sb.pop_front();
    if (!s_done) begin
      n_vec++;
      n_bad++;
      $display("FAIL done_timeout: no done after %0d cycles on dut%0d", c, d);
      return;
    end
    if (chk_drv) chk("drv_sequence", {31'd0, drv_ok}, 32'd1);
    chk("latency", c, lat);
    chk("pass", {31'd0, s_pass}, {31'd0, x.pass});
    chk("err_count", {24'd0, s_ec}, {24'd0, x.cnt});
    chk("err_mask", {25'd0, s_em}, {25'd0, x.mask});
    chk("first_fail", {30'd0, s_ff}, {30'd0, x.ff});
    @(negedge clk);
    chk("post_done", {29'd0, s_done, s_busy, s_pass}, {31'd0, x.pass});
  endtask

  initial begin
    int   c;
    bit   saw_done;
    exp_t e;
    rst_n   = 1'b0;
    start_v = 3'b000;
    sel     = 0;
    for (int i = 0; i < 3; i++) begin
      stuck[i] = '0;
      inv[i]   = '0;
    end

    //            stuck0        inv           pass cnt    mask          ff
    tbl[0] = '{7'b0000000, 7'b0000000, '{1'b1, 8'd0, 7'b0000000, 2'b00}};
    tbl[1] = '{7'b0010000, 7'b0000000, '{1'b0, 8'd2, 7'b0010000, 2'b01}};
    tbl[2] = '{7'b0000000, 7'b1111111, '{1'b0, 8'd4, 7'b1111111, 2'b00}};
    tbl[3] = '{7'b1000000, 7'b0000000, '{1'b0, 8'd2, 7'b1000000, 2'b00}};
    tbl[4] = '{7'b0000001, 7'b0000000, '{1'b0, 8'd1, 7'b0000001, 2'b11}};
    tbl[5] = '{7'b0000000, 7'b0000100, '{1'b0, 8'd4, 7'b0000100, 2'b00}};
    tbl[6] = '{7'b0001000, 7'b0100000, '{1'b0, 8'd4, 7'b0101000, 2'b00}};

    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      sel = d;
      #1;
      chk("reset_state", {16'd0, s_da, s_db, s_busy, s_done, s_pass, s_ec, s_em, s_ff},
          32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++)
      run_one(0, tbl[i].stuck0, tbl[i].inv, tbl[i].e, 13, i == 0, i == 2);

    // Back-to-back: second start lands in the cycle after done.
    run_one(0, tbl[0].stuck0, tbl[0].inv, tbl[0].e, 13, 1'b1, 1'b0);
    run_one(0, tbl[1].stuck0, tbl[1].inv, tbl[1].e, 13, 1'b0, 1'b0);

    e = '{1'b0, 8'd12, 7'b0000010, 2'b00};
    run_one(1, 7'b0000000, 7'b0000010, e, 37, 1'b0, 1'b0);

    e = '{1'b0, 8'd3, 7'b1111111, 2'b00};
    run_one(2, 7'b0000000, 7'b1111111, e, 25, 1'b0, 1'b0);

    // Reset during the third vector.
    sel      = 0;
    stuck[0] = '0;
    inv[0]   = 7'b1111111;
    start_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (7) @(negedge clk);
    chk("mid_run_vec", {24'd0, s_ec, s_da, s_db, s_busy}, {24'd0, 8'd2, 2'b10, 1'b1});
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", {16'd0, s_da, s_db, s_busy, s_done, s_pass, s_ec, s_em, s_ff},
        32'd0);
    saw_done = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (c = 0; c < 20; c++) begin
      if (s_done || s_busy) saw_done = 1'b1;
      @(negedge clk);
    end
    chk("no_done_after_abort", {31'd0, saw_done}, 32'd0);

    // Start held across reset release must not launch a run.
    rst_n      = 1'b0;
    start_v[0] = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    saw_done = 1'b0;
    for (c = 0; c < 5; c++) begin
      if (s_busy) saw_done = 1'b1;
      @(negedge clk);
    end
    chk("start_at_release", {31'd0, saw_done}, 32'd0);

    run_one(0, tbl[0].stuck0, tbl[0].inv, tbl[0].e, 13, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/gate_response_checker.md
Name: gate_response_checker

Overview:
- Hardware counterpart of the gate stimulus bench. It drives every A/B combination into a 2-input logic-gate block and samples the seven gate outputs it returns.
- It compares those outputs against golden values computed internally, then accumulates error information.
- Sits beside a logic-gate instance as a self-test (BIST-style) response analyser. It gives a pass/fail verdict without simulator-side checking.

Parameters:
- SETTLE_CYCLES, 2, clock cycles to wait after changing drv_a/drv_b before sampling gate_y (legal range 1..15).
- LOOPS, 1, number of complete 4-vector sweeps per run (legal range 1..255).
- ERR_W, 8, width of err_count.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a run; ignored while busy.
- gate_y  input  7  returned outputs: [0]and [1]nand [2]or [3]nor [4]xor [5]xnor [6]not(A).
- drv_a  output  1  stimulus A to gate block.
- drv_b  output  1  stimulus B to gate block.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when a run finishes.
- pass  output  1  high when the last completed run had zero mismatches; held until the next start.
- err_count  output  ERR_W  number of mismatching samples (vectors, not bits); saturates at all-ones.
- err_mask  output  7  sticky OR of mismatching gate_y bits over the run.
- first_fail  output  2  {A,B} of the first mismatching vector; valid only when pass=0.

Behaviour:
- Reset (async assert, sync-free deassert to IDLE): drv_a=0, drv_b=0, busy=0, done=0, pass=0, err_count=0, err_mask=0, first_fail=0.
- Vector order is {A,B} = 00, 01, 10, 11, driven from a 2-bit vector counter vec; drv_a=vec[1], drv_b=vec[0].
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE:
  - start=1 -> clear err_count, err_mask, first_fail and pass; set vec=0, loop=0, settle counter=SETTLE_CYCLES-1; busy=1 from the next cycle.
  - Go to SETTLE.
- SETTLE: decrement the settle counter each cycle; at 0 go to CHECK. Total time between a drive change and the sample is exactly SETTLE_CYCLES cycles.
- CHECK (one cycle): compare gate_y against golden = {~A, ~(A^B), A^B, ~(A|B), A|B, ~(A&B), A&B}.
  - On any mismatch: err_count += 1 (saturating), err_mask |= (gate_y ^ golden).
  - On the first mismatch of the run, also load first_fail={A,B}.
- Leaving CHECK:
  - If vec=3 and loop=LOOPS-1 -> DONE.
  - Else vec wraps 3->0 and increments loop; otherwise vec+1. Reload the settle counter and go to SETTLE.
- DONE (one cycle): done=1, busy=0, pass=(err_count==0); then IDLE. Drivers hold the last vector (11) until the next start.
- Latency: start to done = 1 + 4*LOOPS*(SETTLE_CYCLES+1) cycles. Default values give 13.
- start while busy or in DONE is ignored; no queuing.
- A start in the same cycle rst_n deasserts is ignored.
- Reset mid-run aborts immediately to reset values; no done pulse.
- gate_y is assumed stable during CHECK only; X on gate_y counts as a mismatch in simulation (use !== semantics in the bench, not in RTL).

Decomposition:
- Package gate_chk_pkg:
  - Bit-index constants for gate_y: AND_I=0 … NOT_I=6.
  - Typedef for FSM state enum.
  - Function golden(a,b) returning 7 bits.
- One natural sub-module: gate_golden_model (pure combinational golden vector from A,B). This is shared with future gate-level checkers.
- FSM, counters and accumulators stay in the top.

Test Plan:
- Correct gate block connected, SETTLE_CYCLES=2, LOOPS=1, pulse start -> done at cycle 13 after start; pass=1, err_count=0, err_mask=0; drv sequence 00,01,10,11, each held 3 cycles.
- gate_y[4] (xor) stuck at 0 -> mismatches at vectors 01 and 10; err_count=2, err_mask=7'b0010000, first_fail=2'b01, pass=0.
- LOOPS=3 with nand output inverted -> err_count=12, err_mask=7'b0000010, first_fail=00, done at cycle 1+12*3=37.
- ERR_W=2, LOOPS=2, all outputs inverted -> err_count saturates at 3, err_mask=7'h7F.
- rst_n pulsed low during the third vector -> all outputs return to reset values asynchronously; no done pulse; a new start afterwards yields a clean full run with pass=1.
- start re-pulsed while busy -> ignored, latency unchanged; start pulsed in the cycle after done -> new run accepted and pass cleared.
